// File: rtl/dmem_access_arbiter_pkg.sv
// Shared types for the data-memory access arbiter: FSM state encoding and access-type codes.
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_STROBE  = 3'd3,
        ST_RELEASE = 3'd4,
        ST_ERRACK  = 3'd5
    } arb_state_t;

    localparam logic [1:0] TYPE_WORD = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_BYTE = 2'b10;
    localparam logic [1:0] TYPE_ILL  = 2'b11;

    function automatic logic is_illegal(input logic [1:0] t);
        return t == TYPE_ILL;
    endfunction

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_access_arbiter.
// slave = arbiter view, master = requesters plus memory (the surrounding system).
interface dmem_access_arbiter_if #(parameter int AW = 32);

    logic          REQ0,   REQ1;
    logic [AW-1:0] ADDR0,  ADDR1;
    logic [31:0]   WDATA0, WDATA1;
    logic [1:0]    TYPE0,  TYPE1;
    logic          RW0,    RW1;
    logic          LOCK0,  LOCK1;
    logic          GNT0,   GNT1;
    logic          ACK0,   ACK1;
    logic          ERR0,   ERR1;
    logic [31:0]   RDATA0, RDATA1;
    logic [AW-1:0] MADD;
    logic [31:0]   MDATA;
    logic [1:0]    MTYPE;
    logic          MRW;
    logic [31:0]   MDOUT;

    modport slave (
        input  REQ0, REQ1, ADDR0, ADDR1, WDATA0, WDATA1, TYPE0, TYPE1,
               RW0, RW1, LOCK0, LOCK1, MDOUT,
        output GNT0, GNT1, ACK0, ACK1, ERR0, ERR1, RDATA0, RDATA1,
               MADD, MDATA, MTYPE, MRW
    );

    modport master (
        output REQ0, REQ1, ADDR0, ADDR1, WDATA0, WDATA1, TYPE0, TYPE1,
               RW0, RW1, LOCK0, LOCK1, MDOUT,
        input  GNT0, GNT1, ACK0, ACK1, ERR0, ERR1, RDATA0, RDATA1,
               MADD, MDATA, MTYPE, MRW
    );

endinterface

// File: rtl/dmem_access_arbiter_rr_pick.sv
// Two-way winner select: round-robin with bounded LOCK bursts.
// DMEM_ARB_FIXED_PRIO_EN: port 0 always wins; LOCK only affects port 1 and yields to any REQ0.
module dmem_rr_pick #(
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic ack0,
    input  logic ack1,
    input  logic lock0,
    input  logic lock1,
    input  logic take,
    output logic valid,
    output logic win
);

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    logic       prio_q, prio_d;
    logic       own_q,  own_d;
    logic       lock_q, lock_d;
    logic [3:0] cnt_q,  cnt_d;

    logic eff0, eff1, own_req, own_ack, under_max, lock_wait, win_lock;

    always_comb begin
        // A port's REQ in its own ACK cycle still belongs to the finished access.
        eff0      = req0 & ~ack0;
        eff1      = req1 & ~ack1;
        own_req   = own_q ? eff1 : eff0;
        own_ack   = own_q ? ack1 : ack0;
        under_max = cnt_q < BMAX;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        lock_wait = lock_q & own_ack & under_max & ~req0;
        win       = ~eff0;
        win_lock  = win & lock1;
`else
        // Hold the bus one cycle for the lock owner so it can re-present its next request.
        lock_wait = lock_q & own_ack & under_max;
        if (lock_q && own_req && under_max) begin
            win = own_q;
        end else if (eff0 && eff1) begin
            win = prio_q;
        end else begin
            win = eff1;
        end
        win_lock  = win ? lock1 : lock0;
`endif
        valid = (eff0 | eff1) & ~lock_wait;

        prio_d = prio_q;
        own_d  = own_q;
        lock_d = lock_q;
        cnt_d  = cnt_q;
        if (take) begin
            prio_d = ~win;
            if (win_lock) begin
                lock_d = 1'b1;
                own_d  = win;
                if (lock_q && (own_q == win)) begin
                    cnt_d = under_max ? cnt_q + 4'd1 : cnt_q;
                end else begin
                    cnt_d = 4'd1;
                end
            end else begin
                lock_d = 1'b0;
                cnt_d  = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
            own_q  <= 1'b0;
            lock_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            prio_q <= prio_d;
            own_q  <= own_d;
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares one asynchronous data memory between CPU (port 0) and DMA (port 1) with a glitch-free write cycle.
// Arbitration mode selected by DMEM_ARB_FIXED_PRIO_EN (see dmem_rr_pick).
//   state   | meaning
//   IDLE    | pick winner, latch request onto memory bus, pulse GNT
//   SETUP   | address/data settle; writes raise MRW
//   SAMPLE  | capture MDOUT into RDATA, pulse ACK
//   STROBE  | MRW drops, address/data held
//   RELEASE | write done, pulse ACK
//   ERRACK  | illegal type, pulse ACK+ERR, memory untouched
module dmem_access_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int AW        = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    dmem_access_arbiter_if.slave bus
);

    arb_state_t    state_q,  state_d;
    logic          port_q,   port_d;
    logic          wr_q,     wr_d;
    logic [AW-1:0] madd_q,   madd_d;
    logic [31:0]   mdata_q,  mdata_d;
    logic [1:0]    mtype_q,  mtype_d;
    logic          mrw_q,    mrw_d;
    logic          gnt0_q,   gnt0_d, gnt1_q, gnt1_d;
    logic          ack0_q,   ack0_d, ack1_q, ack1_d;
    logic          err0_q,   err0_d, err1_q, err1_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;

    logic          pick_valid, pick_win, grant_en;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [1:0]    sel_type;
    logic          sel_rw;

    assign grant_en = (state_q == ST_IDLE) && pick_valid;

    dmem_rr_pick #(.BURST_MAX(BURST_MAX)) u_pick (
        .clk   (CLK),
        .rst   (RST),
        .req0  (bus.REQ0),
        .req1  (bus.REQ1),
        .ack0  (ack0_q),
        .ack1  (ack1_q),
        .lock0 (bus.LOCK0),
        .lock1 (bus.LOCK1),
        .take  (grant_en),
        .valid (pick_valid),
        .win   (pick_win)
    );

    always_comb begin
        sel_addr  = pick_win ? bus.ADDR1  : bus.ADDR0;
        sel_wdata = pick_win ? bus.WDATA1 : bus.WDATA0;
        sel_type  = pick_win ? bus.TYPE1  : bus.TYPE0;
        sel_rw    = pick_win ? bus.RW1    : bus.RW0;
    end

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        wr_d     = wr_q;
        madd_d   = madd_q;
        mdata_d  = mdata_q;
        mtype_d  = mtype_q;
        mrw_d    = mrw_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                mrw_d = 1'b0;
                if (grant_en) begin
                    port_d = pick_win;
                    gnt0_d = ~pick_win;
                    gnt1_d = pick_win;
                    if (is_illegal(sel_type)) begin
                        state_d = ST_ERRACK;
                    end else begin
                        madd_d  = sel_addr;
                        mdata_d = sel_wdata;
                        mtype_d = sel_type;
                        wr_d    = sel_rw;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (wr_q) begin
                    mrw_d   = 1'b1;
                    state_d = ST_STROBE;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (port_q) begin
                    rdata1_d = bus.MDOUT;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = bus.MDOUT;
                    ack0_d   = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_STROBE: begin
                // Address and data stay put; only the strobe moves on this edge.
                mrw_d   = 1'b0;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                ack0_d  = ~port_q;
                ack1_d  = port_q;
                state_d = ST_IDLE;
            end
            ST_ERRACK: begin
                ack0_d  = ~port_q;
                ack1_d  = port_q;
                err0_d  = ~port_q;
                err1_d  = port_q;
                state_d = ST_IDLE;
            end
            default: begin
                mrw_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            port_q   <= 1'b0;
            wr_q     <= 1'b0;
            madd_q   <= '0;
            mdata_q  <= '0;
            mtype_q  <= TYPE_WORD;
            mrw_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            wr_q     <= wr_d;
            madd_q   <= madd_d;
            mdata_q  <= mdata_d;
            mtype_q  <= mtype_d;
            mrw_q    <= mrw_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.GNT0   = gnt0_q;
    assign bus.GNT1   = gnt1_q;
    assign bus.ACK0   = ack0_q;
    assign bus.ACK1   = ack1_q;
    assign bus.ERR0   = err0_q;
    assign bus.ERR1   = err1_q;
    assign bus.RDATA0 = rdata0_q;
    assign bus.RDATA1 = rdata1_q;
    assign bus.MADD   = madd_q;
    assign bus.MDATA  = mdata_q;
    assign bus.MTYPE  = mtype_q;
    assign bus.MRW    = mrw_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter: per-port expected-completion queues, grant-order log,
// write-strobe monitor and a behavioural asynchronous memory.
module tb_dmem_access_arbiter;
    import dmem_arb_pkg::*;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    dmem_access_arbiter_if #(.AW(32)) bus();

    dmem_access_arbiter #(.BURST_MAX(4), .AW(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem    [16];
    logic [31:0] shadow [16];
    assign bus.MDOUT = mem[bus.MADD[5:2]];

    int   checks   = 0;
    int   failures = 0;
    exp_t exp0[$];
    exp_t exp1[$];
    int   gnt_log[$];
    int   mrw_cycles   = 0;
    int   mrw_run      = 0;
    int   mrw_last_run = 0;
    logic [31:0] madd_prev    = '0;
    logic [31:0] madd_strobe  = '0;
    logic [1:0]  mtype_strobe = '0;
    logic        post_chk     = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic chk_log(input string tag, input int want[$]);
        chk({tag, "_len"}, gnt_log.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            if (i < gnt_log.size()) chk(tag, gnt_log[i], want[i]);
        end
    endtask

    // Memory: writes on the rising edge while MRW is high, reads combinationally.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i * 257);
        mem[1] = 32'h1122_3344;
        forever begin
            @(posedge clk);
            if (bus.MRW) mem[bus.MADD[5:2]] = bus.MDATA;
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.GNT0) gnt_log.push_back(0);
            if (bus.GNT1) gnt_log.push_back(1);
            if (bus.ERR0 && !bus.ACK0) chk("err0_without_ack", 1, 0);
            if (bus.ERR1 && !bus.ACK1) chk("err1_without_ack", 1, 0);
            if (bus.ACK0) begin
                if (exp0.size() == 0) chk("ack0_unexpected", 1, 0);
                else begin
                    e = exp0.pop_front();
                    chk("err0", bus.ERR0, e.err);
                    if (e.rd) chk("rdata0", bus.RDATA0, e.data);
                end
            end
            if (bus.ACK1) begin
                if (exp1.size() == 0) chk("ack1_unexpected", 1, 0);
                else begin
                    e = exp1.pop_front();
                    chk("err1", bus.ERR1, e.err);
                    if (e.rd) chk("rdata1", bus.RDATA1, e.data);
                end
            end
            if (post_chk && !rst) chk("madd_hold_after_strobe", bus.MADD, madd_strobe);
            post_chk = 1'b0;
            if (bus.MRW) begin
                mrw_cycles++;
                mrw_run++;
                chk("madd_hold_before_strobe", bus.MADD, madd_prev);
                madd_strobe  = bus.MADD;
                mtype_strobe = bus.MTYPE;
                post_chk     = 1'b1;
            end else if (mrw_run != 0) begin
                mrw_last_run = mrw_run;
                mrw_run      = 0;
            end
            madd_prev = bus.MADD;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] typ, input logic rw, input logic lock,
                          output int gnt_lat, output int ack_lat);
        exp_t e;
        e.err  = (typ == TYPE_ILL);
        e.rd   = !rw && (typ != TYPE_ILL);
        e.data = shadow[addr[5:2]];
        if (rw && (typ != TYPE_ILL)) shadow[addr[5:2]] = wdata;
        if (p == 0) begin
            exp0.push_back(e);
            bus.ADDR0 = addr; bus.WDATA0 = wdata; bus.TYPE0 = typ;
            bus.RW0 = rw; bus.LOCK0 = lock; bus.REQ0 = 1'b1;
        end else begin
            exp1.push_back(e);
            bus.ADDR1 = addr; bus.WDATA1 = wdata; bus.TYPE1 = typ;
            bus.RW1 = rw; bus.LOCK1 = lock; bus.REQ1 = 1'b1;
        end
        gnt_lat = -1;
        ack_lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (gnt_lat < 0 && ((p == 0) ? bus.GNT0 : bus.GNT1)) gnt_lat = c;
            if ((p == 0) ? bus.ACK0 : bus.ACK1) begin
                ack_lat = c;
                break;
            end
        end
        if (p == 0) bus.REQ0 = 1'b0;
        else        bus.REQ1 = 1'b0;
        if (ack_lat < 0) chk("ack_timeout", 0, 1);
    endtask

    int gl, al, gl0, al0, gl1, al1, mc, acks;
    logic        found;
    logic [31:0] madd_before;
    int          want[$];

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = 32'h1000_0000 + 32'(i * 257);
        shadow[1] = 32'h1122_3344;
        rst = 1'b1;
        bus.REQ0 = 0; bus.REQ1 = 0; bus.ADDR0 = 0; bus.ADDR1 = 0;
        bus.WDATA0 = 0; bus.WDATA1 = 0; bus.TYPE0 = 0; bus.TYPE1 = 0;
        bus.RW0 = 0; bus.RW1 = 0; bus.LOCK0 = 0; bus.LOCK1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_mrw", bus.MRW, 0);
        chk("rst_madd", bus.MADD, 0);
        chk("rst_mdata", bus.MDATA, 0);
        chk("rst_pulses", {bus.GNT0, bus.GNT1, bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1}, 0);
        chk("rst_rdata", {bus.RDATA0, bus.RDATA1}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Contention straight out of reset: port 0 first, then strict alternation.
        gnt_log.delete();
        fork
            for (int i = 0; i < 3; i++) do_req(0, 32'h10 + 32'(4 * i), 0, TYPE_WORD, 0, 0, gl0, al0);
            for (int i = 0; i < 3; i++) do_req(1, 32'h20 + 32'(4 * i), 0, TYPE_WORD, 0, 0, gl1, al1);
        join
        want = '{0, 1, 0, 1, 0, 1};
        chk_log("contention_order", want);
        repeat (2) @(negedge clk);

        // Solo read.
        mc = mrw_cycles;
        do_req(0, 32'h4, 0, TYPE_WORD, 0, 0, gl, al);
        chk("read_gnt_lat", gl, 1);
        chk("read_ack_lat", al, 3);
        chk("read_no_mrw", mrw_cycles - mc, 0);
        chk("read_rdata_direct", bus.RDATA0, 32'h1122_3344);
        @(negedge clk);

        // Solo byte write, then read it back.
        mc = mrw_cycles;
        do_req(1, 32'h8, 32'hA5, TYPE_BYTE, 1, 0, gl, al);
        chk("write_gnt_lat", gl, 1);
        chk("write_ack_lat", al, 4);
        chk("write_mrw_cycles", mrw_cycles - mc, 1);
        chk("write_mrw_run", mrw_last_run, 1);
        chk("write_madd", madd_strobe, 32'h8);
        chk("write_mtype", mtype_strobe, TYPE_BYTE);
        do_req(0, 32'h8, 0, TYPE_WORD, 0, 0, gl, al);
        chk("readback_ack_lat", al, 3);
        @(negedge clk);

        // Illegal type: error completion, memory bus untouched.
        mc = mrw_cycles;
        madd_before = bus.MADD;
        do_req(0, 32'h30, 32'hFFFF, TYPE_ILL, 1, 0, gl, al);
        chk("ill_gnt_lat", gl, 1);
        chk("ill_ack_lat", al, 2);
        chk("ill_no_mrw", mrw_cycles - mc, 0);
        chk("ill_madd_kept", bus.MADD, madd_before);
        @(negedge clk);

        // Locked burst on port 1 with port 0 waiting.
        gnt_log.delete();
        fork
            for (int i = 0; i < 5; i++) do_req(1, 32'h20 + 32'(4 * i), 0, TYPE_WORD, 0, 1, gl1, al1);
            begin
                found = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (bus.GNT1) begin
                        found = 1'b1;
                        break;
                    end
                end
                chk("burst_first_gnt1", found, 1);
                do_req(0, 32'h4, 0, TYPE_WORD, 0, 0, gl0, al0);
            end
        join
`ifdef DMEM_ARB_FIXED_PRIO_EN
        want = '{1, 0, 1, 1, 1, 1};
`else
        want = '{1, 1, 1, 1, 0, 1};
`endif
        chk_log("burst_order", want);
        @(negedge clk);

        // Reset during the write strobe aborts the access without an ACK.
        bus.ADDR1 = 32'hC; bus.WDATA1 = 32'hDEAD_BEEF; bus.TYPE1 = TYPE_WORD;
        bus.RW1 = 1'b1; bus.LOCK1 = 1'b0; bus.REQ1 = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.MRW) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_strobe_reached", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mrw", bus.MRW, 0);
        chk("abort_ack1", bus.ACK1, 0);
        chk("abort_madd", bus.MADD, 0);
        rst = 1'b0;
        bus.REQ1 = 1'b0;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ACK1 || bus.ACK0) acks++;
        end
        chk("abort_no_ack", acks, 0);
        do_req(0, 32'h4, 0, TYPE_WORD, 0, 0, gl, al);
        chk("post_abort_gnt_lat", gl, 1);
        chk("post_abort_ack_lat", al, 3);

        repeat (3) @(negedge clk);
        chk("exp0_drained", exp0.size(), 0);
        chk("exp1_drained", exp1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
